// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// access sizes and byte-enable patterns.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DATA  = 2'b10
    } state_t;

    // Encoding matches the d_size port; 2'b11 is reserved and behaves as a word
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for data accesses: turns size and the low
// address bits into byte enables, lane-replicated store data and a
// misalignment flag.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic        misalign
);

    // Decode the access width into lanes; reserved size falls through as a word
    always_comb begin
        byteenable = BE_WORD;
        writedata  = wdata;
        misalign   = 1'b0;
        case (size)
            SZ_BYTE: begin
                byteenable = BE_BYTE0 << addr_lo;
                writedata  = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byteenable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                writedata  = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            SZ_WORD: begin
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM master port between instruction fetch and data
// load/store. Data wins ties, each access runs through the waitrequest
// handshake, and all bus-side outputs are registered.
// Optional feature: define MEM_ARB_PERF_CNT_EN to add wait-cycle and
// completed-transaction counters (and the PERF_W parameter).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              stall,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_wait_cycles,
    output logic [PERF_W-1:0] perf_txn_count
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  next_address;
    logic               next_read;
    logic               next_write;
    logic [3:0]         next_be;
    logic [31:0]        next_wdata;
    logic [31:0]        next_if_rdata;
    logic [31:0]        next_d_rdata;
    logic               next_if_valid;
    logic               next_d_valid;
    logic               next_d_err;

    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic               lane_misalign;
    logic               d_take;
    logic               if_take;

    mem_lane_align u_lane_align (
        .size       (d_size),
        .addr_lo    (d_addr[1:0]),
        .wdata      (d_wdata),
        .byteenable (lane_be),
        .writedata  (lane_wdata),
        .misalign   (lane_misalign)
    );

    // A requester whose completion pulse is showing must not be granted again
    assign d_take  = d_req  & ~d_valid;
    assign if_take = if_req & ~if_valid;

    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

    // Next-state and next-output decode; bus outputs hold by default so a waitrequest freezes them
    always_comb begin
        next_state    = state;
        next_address  = avm_address;
        next_read     = avm_read;
        next_write    = avm_write;
        next_be       = avm_byteenable;
        next_wdata    = avm_writedata;
        next_if_rdata = if_rdata;
        next_d_rdata  = d_rdata;
        next_if_valid = 1'b0;
        next_d_valid  = 1'b0;
        next_d_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_take) begin
                    if (lane_misalign) begin
                        next_d_valid = 1'b1;
                        next_d_err   = 1'b1;
                    end else begin
                        next_address = d_addr & ALIGN_MASK;
                        next_read    = ~d_write;
                        next_write   = d_write;
                        next_be      = lane_be;
                        next_wdata   = lane_wdata;
                        next_state   = ST_DATA;
                    end
                end else if (if_take) begin
                    next_address = if_addr & ALIGN_MASK;
                    next_read    = 1'b1;
                    next_write   = 1'b0;
                    next_be      = BE_WORD;
                    next_state   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!avm_waitrequest) begin
                    next_read     = 1'b0;
                    next_write    = 1'b0;
                    next_if_rdata = avm_readdata;
                    next_if_valid = 1'b1;
                    next_state    = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!avm_waitrequest) begin
                    if (avm_read) begin
                        next_d_rdata = avm_readdata;
                    end
                    next_read    = 1'b0;
                    next_write   = 1'b0;
                    next_d_valid = 1'b1;
                    next_state   = ST_IDLE;
                end
            end
            default: begin
                next_read  = 1'b0;
                next_write = 1'b0;
                next_state = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the strobes at once and abandons any access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            if_rdata       <= '0;
            d_rdata        <= '0;
            if_valid       <= 1'b0;
            d_valid        <= 1'b0;
            d_err          <= 1'b0;
        end else begin
            state          <= next_state;
            avm_address    <= next_address;
            avm_read       <= next_read;
            avm_write      <= next_write;
            avm_byteenable <= next_be;
            avm_writedata  <= next_wdata;
            if_rdata       <= next_if_rdata;
            d_rdata        <= next_d_rdata;
            if_valid       <= next_if_valid;
            d_valid        <= next_d_valid;
            d_err          <= next_d_err;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    // Count stalled strobe cycles and finished bus transactions; both wrap freely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_wait_cycles <= '0;
            perf_txn_count   <= '0;
        end else begin
            if ((avm_read | avm_write) & avm_waitrequest) begin
                perf_wait_cycles <= perf_wait_cycles + 1'b1;
            end
            if ((avm_read | avm_write) & ~avm_waitrequest) begin
                perf_txn_count <= perf_txn_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. The bench plays the
// memory slave by driving waitrequest/readdata cycle by cycle. Counter
// checks are compiled in when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        stall;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_wait_cycles;
    logic [31:0] perf_txn_count;
`endif

    int checkCount = 0;
    int errorCount = 0;

    mem_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_rdata        (if_rdata),
        .if_valid        (if_valid),
        .d_req           (d_req),
        .d_write         (d_write),
        .d_size          (d_size),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .d_valid         (d_valid),
        .d_err           (d_err),
        .stall           (stall),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_wait_cycles(perf_wait_cycles),
        .perf_txn_count  (perf_txn_count)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge, where outputs have settled
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the data-side request payload
    task automatic applyStimulus(input logic req, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        d_req   = req;
        d_write = wr;
        d_size  = sz;
        d_addr  = addr;
        d_wdata = wdata;
    endtask

    initial begin
        reset           = 1'b1;
        if_req          = 1'b0;
        if_addr         = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        checkOutput("rst_read", {31'd0, avm_read}, 32'd0);
        checkOutput("rst_write", {31'd0, avm_write}, 32'd0);
        checkOutput("rst_addr", avm_address, 32'h0);
        checkOutput("rst_be", {28'd0, avm_byteenable}, 32'h0);
        checkOutput("rst_flags", {29'd0, if_valid, d_valid, d_err}, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Fetch with no wait: strobe in cycle 1, if_valid in cycle 2
        if_req       = 1'b1;
        if_addr      = 32'h0000_0102;
        avm_readdata = 32'h2408_0005;
        #1;
        checkOutput("f1_stall_c0", {31'd0, stall}, 32'd1);
        step();
        checkOutput("f1_read_c1", {31'd0, avm_read}, 32'd1);
        checkOutput("f1_addr_c1", avm_address, 32'h0000_0100);
        checkOutput("f1_be_c1", {28'd0, avm_byteenable}, 32'hF);
        checkOutput("f1_valid_c1", {31'd0, if_valid}, 32'd0);
        step();
        checkOutput("f1_valid_c2", {31'd0, if_valid}, 32'd1);
        checkOutput("f1_rdata_c2", if_rdata, 32'h2408_0005);
        checkOutput("f1_read_c2", {31'd0, avm_read}, 32'd0);
        checkOutput("f1_stall_c2", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        step();
        checkOutput("f1_valid_c3", {31'd0, if_valid}, 32'd0);
        checkOutput("f1_read_c3", {31'd0, avm_read}, 32'd0);

        // Fetch and load word together: data first, fetch after one idle cycle
        if_req       = 1'b1;
        if_addr      = 32'h0000_0200;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0);
        avm_readdata = 32'hDEAD_BEEF;
        step();
        checkOutput("arb_read_c1", {31'd0, avm_read}, 32'd1);
        checkOutput("arb_addr_c1", avm_address, 32'h0000_1000);
        step();
        checkOutput("arb_dvalid_c2", {31'd0, d_valid}, 32'd1);
        checkOutput("arb_drdata_c2", d_rdata, 32'hDEAD_BEEF);
        checkOutput("arb_idle_c2", {31'd0, avm_read}, 32'd0);
        checkOutput("arb_stall_c2", {31'd0, stall}, 32'd1);
        d_req        = 1'b0;
        avm_readdata = 32'h1111_2222;
        step();
        checkOutput("arb_fread_c3", {31'd0, avm_read}, 32'd1);
        checkOutput("arb_faddr_c3", avm_address, 32'h0000_0200);
        step();
        checkOutput("arb_fvalid_c4", {31'd0, if_valid}, 32'd1);
        checkOutput("arb_frdata_c4", if_rdata, 32'h1111_2222);
        checkOutput("arb_drdata_c4", d_rdata, 32'hDEAD_BEEF);
        if_req = 1'b0;
        step();

        // Misaligned halfword store: error pulse in cycle 1, no bus write
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h0000_1001, 32'h0000_1234);
        step();
        checkOutput("mis_dvalid_c1", {31'd0, d_valid}, 32'd1);
        checkOutput("mis_derr_c1", {31'd0, d_err}, 32'd1);
        checkOutput("mis_write_c1", {31'd0, avm_write}, 32'd0);
        d_req = 1'b0;
        step();
        checkOutput("mis_write_c2", {31'd0, avm_write}, 32'd0);
        checkOutput("mis_derr_c2", {31'd0, d_err}, 32'd0);

        // Misaligned word load also errors
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h0000_1002, 32'h0);
        step();
        checkOutput("misw_derr_c1", {31'd0, d_err}, 32'd1);
        checkOutput("misw_read_c1", {31'd0, avm_read}, 32'd0);
        d_req = 1'b0;
        step();

        // Aligned upper halfword store: lanes 3:2, data replicated
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h0000_1002, 32'hFFFF_1234);
        step();
        checkOutput("sh_write_c1", {31'd0, avm_write}, 32'd1);
        checkOutput("sh_be_c1", {28'd0, avm_byteenable}, 32'hC);
        checkOutput("sh_wdata_c1", avm_writedata, 32'h1234_1234);
        step();
        checkOutput("sh_dvalid_c2", {31'd0, d_valid}, 32'd1);
        checkOutput("sh_derr_c2", {31'd0, d_err}, 32'd0);
        d_req = 1'b0;
        step();

        // Fresh reset so the counters start from zero
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Byte store to lane 3 with three wait cycles
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB);
        avm_waitrequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            checkOutput($sformatf("sb_write_c%0d", c), {31'd0, avm_write}, 32'd1);
            checkOutput($sformatf("sb_be_c%0d", c), {28'd0, avm_byteenable}, 32'h8);
            checkOutput($sformatf("sb_wdata_c%0d", c), avm_writedata, 32'hABAB_ABAB);
            checkOutput($sformatf("sb_addr_c%0d", c), avm_address, 32'h0000_1000);
            checkOutput($sformatf("sb_dvalid_c%0d", c), {31'd0, d_valid}, 32'd0);
        end
        avm_waitrequest = 1'b0;
        step();
        checkOutput("sb_dvalid_c5", {31'd0, d_valid}, 32'd1);
        checkOutput("sb_write_c5", {31'd0, avm_write}, 32'd0);
        checkOutput("sb_drdata_c5", d_rdata, 32'h0);
        d_req = 1'b0;
        step();

        // Plain fetch again, no wait
        if_req       = 1'b1;
        if_addr      = 32'h0000_0100;
        avm_readdata = 32'h2408_0005;
        step();
        step();
        checkOutput("f2_valid_c2", {31'd0, if_valid}, 32'd1);
        if_req = 1'b0;
        step();
`ifdef MEM_ARB_PERF_CNT_EN
        checkOutput("perf_wait", perf_wait_cycles, 32'd3);
        checkOutput("perf_txn", perf_txn_count, 32'd2);
`endif

        // Reset during a stalled read drops the strobe immediately
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0);
        avm_waitrequest = 1'b1;
        step();
        checkOutput("rr_read_c1", {31'd0, avm_read}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rr_read_async", {31'd0, avm_read}, 32'd0);
        step();
        checkOutput("rr_dvalid_rst", {31'd0, d_valid}, 32'd0);
`ifdef MEM_ARB_PERF_CNT_EN
        checkOutput("rr_perf_clr", perf_txn_count, 32'd0);
`endif
        reset = 1'b0;
        d_req = 1'b0;
        step();
        checkOutput("rr_dvalid_post", {31'd0, d_valid}, 32'd0);
        checkOutput("rr_read_post", {31'd0, avm_read}, 32'd0);
        avm_waitrequest = 1'b0;
        if_req          = 1'b1;
        if_addr         = 32'h0000_0300;
        avm_readdata    = 32'h0BAD_F00D;
        step();
        checkOutput("rr_idle_grant", {31'd0, avm_read}, 32'd1);
        checkOutput("rr_idle_addr", avm_address, 32'h0000_0300);
        step();
        checkOutput("rr_fvalid", {31'd0, if_valid}, 32'd1);
        checkOutput("rr_frdata", if_rdata, 32'h0BAD_F00D);
        if_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
